// File: rtl/vad_energy.sv
`timescale 1ns/1ps
// Energy-based voice activity detector on a raw PDM stream: per-window density
// deviation energy plus a hold/hangover FSM driving vad_o.
module vad_energy #(
  parameter  int SUB_LEN      = 16,
  parameter  int NUM_SUBS     = 64,
  parameter  int HOLD_WINDOWS = 2,
  parameter  int HANG_WINDOWS = 4,
  localparam int ENERGY_BW    = $clog2(NUM_SUBS * SUB_LEN / 2 + 1)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 en_i,
  input  logic                 pdm_data_i,
  input  logic                 pdm_valid_i,
  input  logic [ENERGY_BW-1:0] thresh_i,
  output logic                 vad_o,
  output logic [ENERGY_BW-1:0] energy_o,
  output logic                 energy_valid_o
);

  localparam int ONES_W = $clog2(SUB_LEN + 1);
  localparam int SUB_W  = $clog2(SUB_LEN);
  localparam int IDX_W  = $clog2(NUM_SUBS);

  localparam logic [SUB_W-1:0]  SUB_LAST = SUB_W'(SUB_LEN - 1);
  localparam logic [SUB_W-1:0]  SUB_ONE  = SUB_W'(1);
  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(NUM_SUBS - 1);
  localparam logic [IDX_W-1:0]  IDX_ONE  = IDX_W'(1);
  localparam logic [ONES_W-1:0] HALF     = ONES_W'(SUB_LEN / 2);
  localparam logic [3:0]        HOLD_N   = 4'(HOLD_WINDOWS);
  localparam logic [3:0]        HANG_N   = 4'(HANG_WINDOWS);

  typedef enum logic [1:0] {
    ST_QUIET  = 2'b00,
    ST_ARMING = 2'b01,
    ST_ACTIVE = 2'b10
  } state_t;

  logic [ONES_W-1:0]    ones_cnt_r;
  logic [SUB_W-1:0]     sub_cnt_r;
  logic [IDX_W-1:0]     sub_idx_r;
  logic [ENERGY_BW-1:0] acc_r;
  logic [ENERGY_BW-1:0] energy_r;
  logic                 energy_valid_r;

  logic [ONES_W-1:0]    ones_total_s;
  logic [ONES_W-1:0]    dev_s;
  logic [ENERGY_BW-1:0] win_energy_s;
  logic                 sub_end_s;
  logic                 win_end_s;
  logic                 above_s;

  state_t               state_r, state_s;
  logic [3:0]           run_r, run_s;
  logic [3:0]           quiet_r, quiet_s;
  logic [3:0]           run_inc_s;
  logic [3:0]           quiet_inc_s;

  // Sub-window deviation, running window energy and end-of-window decode
  always_comb begin
    ones_total_s = ones_cnt_r + ONES_W'(pdm_data_i);
    if (ones_total_s >= HALF) begin
      dev_s = ones_total_s - HALF;
    end else begin
      dev_s = HALF - ones_total_s;
    end
    win_energy_s = acc_r + ENERGY_BW'(dev_s);
    sub_end_s    = en_i && pdm_valid_i && (sub_cnt_r == SUB_LAST);
    win_end_s    = sub_end_s && (sub_idx_r == IDX_LAST);
    above_s      = (win_energy_s >= thresh_i);
  end

  // Sample counters, energy accumulator and the published window energy
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ones_cnt_r     <= '0;
      sub_cnt_r      <= '0;
      sub_idx_r      <= '0;
      acc_r          <= '0;
      energy_r       <= '0;
      energy_valid_r <= 1'b0;
    end else if (!en_i) begin
      ones_cnt_r     <= '0;
      sub_cnt_r      <= '0;
      sub_idx_r      <= '0;
      acc_r          <= '0;
      energy_r       <= '0;
      energy_valid_r <= 1'b0;
    end else begin
      energy_valid_r <= 1'b0;
      if (win_end_s) begin
        ones_cnt_r     <= '0;
        sub_cnt_r      <= '0;
        sub_idx_r      <= '0;
        acc_r          <= '0;
        energy_r       <= win_energy_s;
        energy_valid_r <= 1'b1;
      end else if (sub_end_s) begin
        ones_cnt_r <= '0;
        sub_cnt_r  <= '0;
        sub_idx_r  <= sub_idx_r + IDX_ONE;
        acc_r      <= win_energy_s;
      end else if (pdm_valid_i) begin
        ones_cnt_r <= ones_total_s;
        sub_cnt_r  <= sub_cnt_r + SUB_ONE;
      end
    end
  end

  // Hold/hangover next-state logic; only a window end can move the FSM
  always_comb begin
    state_s     = state_r;
    run_s       = run_r;
    quiet_s     = quiet_r;
    run_inc_s   = run_r + 4'd1;
    quiet_inc_s = quiet_r + 4'd1;
    case (state_r)
      ST_QUIET: begin
        if (win_end_s && above_s) begin
          if (HOLD_N == 4'd1) begin
            state_s = ST_ACTIVE;
            quiet_s = 4'd0;
          end else begin
            state_s = ST_ARMING;
            run_s   = 4'd1;
          end
        end else begin
          state_s = ST_QUIET;
        end
      end
      ST_ARMING: begin
        if (win_end_s) begin
          if (!above_s) begin
            state_s = ST_QUIET;
            run_s   = 4'd0;
          end else if (run_inc_s == HOLD_N) begin
            state_s = ST_ACTIVE;
            run_s   = 4'd0;
            quiet_s = 4'd0;
          end else begin
            run_s = run_inc_s;
          end
        end else begin
          state_s = ST_ARMING;
        end
      end
      ST_ACTIVE: begin
        if (win_end_s) begin
          if (above_s) begin
            quiet_s = 4'd0;
          end else if (quiet_inc_s == HANG_N) begin
            state_s = ST_QUIET;
            quiet_s = 4'd0;
            run_s   = 4'd0;
          end else begin
            quiet_s = quiet_inc_s;
          end
        end else begin
          state_s = ST_ACTIVE;
        end
      end
      default: begin
        state_s = ST_QUIET;
        run_s   = 4'd0;
        quiet_s = 4'd0;
      end
    endcase
  end

  // FSM state and run counters
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r <= ST_QUIET;
      run_r   <= 4'd0;
      quiet_r <= 4'd0;
    end else if (!en_i) begin
      state_r <= ST_QUIET;
      run_r   <= 4'd0;
      quiet_r <= 4'd0;
    end else begin
      state_r <= state_s;
      run_r   <= run_s;
      quiet_r <= quiet_s;
    end
  end

  assign vad_o          = (state_r == ST_ACTIVE);
  assign energy_o       = energy_r;
  assign energy_valid_o = energy_valid_r;

endmodule

// File: tb/tb_vad_energy.sv
`timescale 1ns/1ps
// Scoreboard bench for vad_energy: a window-level reference model queues the
// expected energy/vad per window and a negedge monitor checks the DUT.
module tb_vad_energy;
  localparam int SUB_LEN  = 16;
  localparam int NUM_SUBS = 64;
  localparam int HOLD     = 2;
  localparam int HANG     = 4;
  localparam int EBW      = 10;
  localparam int WIN      = SUB_LEN * NUM_SUBS;

  logic           clk_i = 1'b0;
  logic           rst_i = 1'b1;
  logic           en_i = 1'b1;
  logic           pdm_data_i = 1'b0;
  logic           pdm_valid_i = 1'b0;
  logic [EBW-1:0] thresh_i = 10'd100;
  logic           vad_o;
  logic [EBW-1:0] energy_o;
  logic           energy_valid_o;

  vad_energy #(
    .SUB_LEN(SUB_LEN), .NUM_SUBS(NUM_SUBS),
    .HOLD_WINDOWS(HOLD), .HANG_WINDOWS(HANG)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .en_i(en_i),
    .pdm_data_i(pdm_data_i), .pdm_valid_i(pdm_valid_i), .thresh_i(thresh_i),
    .vad_o(vad_o), .energy_o(energy_o), .energy_valid_o(energy_valid_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {int energy; bit vad;} exp_t;
  exp_t exp_q[$];
  bit   win_q[$];
  int   above_run = 0, below_run = 0;
  bit   model_vad = 1'b0;
  int   n_cmp = 0, n_fail = 0;
  int   cyc = 0;
  bit   en_at_edge = 1'b0;
  int   last_ev_cyc = -1;

  task automatic check(string name, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Window energy straight from the definition: sum of |ones - SUB_LEN/2|
  function automatic int window_energy();
    int e = 0;
    for (int s = 0; s < NUM_SUBS; s++) begin
      int ones = 0;
      for (int k = 0; k < SUB_LEN; k++) ones += win_q[s*SUB_LEN + k];
      e += (ones > SUB_LEN/2) ? ones - SUB_LEN/2 : SUB_LEN/2 - ones;
    end
    return e;
  endfunction

  // vad rises after HOLD consecutive loud windows, falls after HANG quiet ones
  task automatic model_sample(bit d);
    win_q.push_back(d);
    if (win_q.size() == WIN) begin
      int e = window_energy();
      if (e >= int'(thresh_i)) begin above_run++; below_run = 0; end
      else begin below_run++; above_run = 0; end
      if (!model_vad && above_run >= HOLD) model_vad = 1'b1;
      else if (model_vad && below_run >= HANG) model_vad = 1'b0;
      exp_q.push_back('{e, model_vad});
      win_q.delete();
    end
  endtask

  task automatic model_clear();
    win_q.delete();
    above_run = 0;
    below_run = 0;
    model_vad = 1'b0;
  endtask

  task automatic step(bit v, bit d);
    @(negedge clk_i);
    pdm_valid_i = v;
    pdm_data_i  = d;
    if (v && en_i && !rst_i) model_sample(d);
  endtask

  // kind 0: 1010..., 1: all ones, 2: 12 ones + 4 zeros per sub-window
  task automatic run_pattern(int nsamp, int kind, int gap);
    for (int i = 0; i < nsamp; i++) begin
      bit d;
      case (kind)
        0: d = (i % 2 == 0);
        1: d = 1'b1;
        default: d = ((i % SUB_LEN) < 12);
      endcase
      step(1'b1, d);
      repeat (gap) step(1'b0, 1'b0);
    end
  endtask

  always @(posedge clk_i) begin
    cyc        <= cyc + 1;
    en_at_edge <= en_i;
  end

  // Monitor: pop on every energy_valid_o, otherwise vad_o must hold
  initial begin
    exp_t e;
    bit cur_vad = 1'b0;
    forever begin
      @(negedge clk_i);
      if (rst_i) begin
        cur_vad = 1'b0;
      end else begin
        if (!en_at_edge) cur_vad = 1'b0;
        if (energy_valid_o) begin
          last_ev_cyc = cyc;
          if (exp_q.size() == 0) begin
            check("unexpected_energy_valid", 1, 0);
          end else begin
            e = exp_q.pop_front();
            check("energy", int'(energy_o), e.energy);
            check("vad_at_window", int'(vad_o), int'(e.vad));
            cur_vad = e.vad;
          end
        end else begin
          check("vad_hold", int'(vad_o), int'(cur_vad));
        end
      end
    end
  end

  initial begin
    int c0;
    repeat (3) @(negedge clk_i);
    #1;
    check("reset_vad", int'(vad_o), 0);
    check("reset_energy", int'(energy_o), 0);
    check("reset_energy_valid", int'(energy_valid_o), 0);
    @(negedge clk_i);
    rst_i = 1'b0;

    // Reset 600 samples into a window, then time the first full window
    for (int i = 0; i < 600; i++) step(1'b1, 1'($urandom_range(0, 1)));
    @(negedge clk_i);
    rst_i = 1'b1;
    pdm_valid_i = 1'b0;
    model_clear();
    #1;
    check("midreset_vad", int'(vad_o), 0);
    check("midreset_energy", int'(energy_o), 0);
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    step(1'b1, 1'($urandom_range(0, 1)));
    c0 = cyc;
    for (int i = 1; i < WIN; i++) step(1'b1, 1'($urandom_range(0, 1)));
    repeat (2) step(1'b0, 1'b0);
    check("first_window_latency", last_ev_cyc - c0, 1024);

    // Quiet alternating windows, loud-then-quiet arming, then activation
    thresh_i = 10'd100;
    run_pattern(3 * WIN, 0, 0);
    check("alt_vad_low", int'(vad_o), 0);
    run_pattern(WIN, 1, 0);
    run_pattern(WIN, 0, 0);
    check("arming_aborted", int'(vad_o), 0);
    run_pattern(2 * WIN, 1, 0);
    repeat (2) step(1'b0, 1'b0);
    check("active_after_two_loud", int'(vad_o), 1);

    // Hangover: loud window inside restarts the quiet count
    run_pattern(3 * WIN, 0, 0);
    run_pattern(WIN, 1, 0);
    run_pattern(3 * WIN, 0, 0);
    repeat (2) step(1'b0, 1'b0);
    check("hang_still_active", int'(vad_o), 1);
    run_pattern(WIN, 0, 0);
    repeat (2) step(1'b0, 1'b0);
    check("hang_expired", int'(vad_o), 0);

    // Energy 256 at the threshold boundary, sparse strobes, then en_i drop
    thresh_i = 10'd256;
    run_pattern(2 * WIN, 2, 3);
    check("thresh_equal_is_above", int'(vad_o), 1);
    thresh_i = 10'd257;
    run_pattern(WIN, 2, 3);
    check("thresh_257_one_quiet", int'(vad_o), 1);
    run_pattern(500, 2, 3);
    @(negedge clk_i);
    en_i = 1'b0;
    pdm_valid_i = 1'b0;
    model_clear();
    @(posedge clk_i);
    #1;
    check("en_drop_vad", int'(vad_o), 0);
    check("en_drop_energy", int'(energy_o), 0);
    for (int i = 0; i < 20; i++) step(1'b1, 1'b1);
    @(negedge clk_i);
    en_i = 1'b1;
    pdm_valid_i = 1'b0;

    // Random windows: biased density, gaps, threshold moving every sample
    for (int w = 0; w < 8; w++) begin
      int prob = 50 + 15 * int'($urandom_range(0, 3));
      for (int i = 0; i < WIN; i++) begin
        bit d;
        thresh_i = (w == 0) ? 10'd0 : 10'($urandom_range(0, 250));
        d = (w == 0) ? (i % 2 == 0) : ($urandom_range(0, 99) < prob);
        step(1'b1, d);
        repeat ($urandom_range(0, 2)) step(1'b0, 1'b0);
      end
    end

    repeat (5) step(1'b0, 1'b0);
    check("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/vad_energy.md
Name: vad_energy

Overview:
- Energy-based voice activity detector directly upstream of the pipeline control block; its vad_o drives that block's voice-activity input.
- Consumes the raw 1-bit PDM microphone stream, measures per-window signal energy as accumulated density deviation from 50 %, and asserts vad_o after sustained energy.
- Deasserts vad_o after a hangover period of quiet.
- Always on; it is never gated by the pipeline enable.

Parameters:
- SUB_LEN, 16: PDM samples per sub-window; must be an even power of two.
- NUM_SUBS, 64: sub-windows per energy window. The window is SUB_LEN*NUM_SUBS = 1024 samples.
- HOLD_WINDOWS, 2: consecutive above-threshold windows required to assert vad_o; range 1..15.
- HANG_WINDOWS, 4: consecutive below-threshold windows required to deassert vad_o; range 1..15.
- ENERGY_BW, $clog2(NUM_SUBS*SUB_LEN/2+1) = 10: energy width (derived localparam).

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  reset
- en_i  in  1  detector enable; low clears datapath and FSM synchronously
- pdm_data_i  in  1  PDM bit, sampled only when pdm_valid_i is high
- pdm_valid_i  in  1  one-cycle strobe per new PDM sample
- thresh_i  in  ENERGY_BW  energy threshold, sampled at each window end
- vad_o  out  1  voice activity level
- energy_o  out  ENERGY_BW  energy of last completed window
- energy_valid_o  out  1  one-cycle pulse when energy_o updates

Interface decision: one clock, clk_i; reset rst_i is asynchronous and active-high.

Behaviour:
Reset (rst_i high, async):
- All counters, the accumulator and energy_o go to 0.
- energy_valid_o = 0, vad_o = 0, FSM = QUIET.
- Reset mid-window discards the partial window.
- The first window after release starts with the first pdm_valid_i.

en_i low:
- Same clearing as reset, applied at the clock edge.
- pdm_valid_i is ignored while en_i is low.

Datapath, per pdm_valid_i:
- ones_cnt increments if pdm_data_i = 1.
- sub_cnt counts 0..SUB_LEN-1.

Sub-window end (valid sample with sub_cnt = SUB_LEN-1):
- ones_total includes the current bit.
- dev = |ones_total − SUB_LEN/2|, range 0..SUB_LEN/2.
- acc += dev; ones_cnt and sub_cnt clear.
- sub_idx counts 0..NUM_SUBS-1.

Window end (sub-window end with sub_idx = NUM_SUBS-1):
- On the same edge: energy_o <= acc + dev, energy_valid_o <= 1 for one cycle, acc <= 0, sub_idx <= 0, and the FSM evaluates above = (acc + dev >= thresh_i).
- Widths are sized so the maximum energy (NUM_SUBS*SUB_LEN/2) never overflows; there is no saturation logic.
- With pdm_valid_i high every cycle, the first energy_valid_o is asserted exactly 1024 cycles after the first strobe.

FSM (updates only at window end; holds otherwise):
- QUIET: if above, go to ACTIVE when HOLD_WINDOWS = 1, else to ARMING with run = 1. If not above, stay.
- ARMING: if above, run+1; when run+1 = HOLD_WINDOWS go to ACTIVE. If not above, go to QUIET with run = 0.
- ACTIVE: if above, quiet_run = 0. If not above, quiet_run+1; when it reaches HANG_WINDOWS go to QUIET.
- Illegal state encoding goes to QUIET.

vad_o timing:
- vad_o = (state == ACTIVE), decoded from the registered state.
- It therefore rises and falls in the cycle following the edge that produced the qualifying energy_valid_o, i.e. coincident with energy_valid_o high.

Boundary conditions:
- thresh_i = 0: every window is above.
- thresh_i changes mid-window: only the value at the window-end edge matters.
- pdm_valid_i gaps of any length are allowed; windows are counted in samples, not cycles.

Test Plan:
- Reset mid-window (600 samples in) then release, with pdm_valid_i every cycle → vad_o = 0 and energy_o = 0 during reset; first energy_valid_o exactly 1024 strobes after release.
- Alternating 1010 pattern for 3 windows, thresh_i = 100 → energy_o = 0 each window; vad_o stays 0.
- All-ones for 2 windows, thresh_i = 100 → energy_o = 512 each window; vad_o rises coincident with the second energy_valid_o.
- One all-ones window then alternating pattern, thresh_i = 100 → energy 512 then 0; FSM goes ARMING then QUIET; vad_o never asserts.
- ACTIVE state then silence → vad_o stays 1 through 3 quiet windows; drops with the 4th quiet window's energy_valid_o. A loud window inside the hangover resets the quiet count.
- 12 ones + 4 zeros per sub-window, pdm_valid_i every 4th cycle → energy 256. thresh_i = 256 counts as above; thresh_i = 257 does not. Dropping en_i mid-window clears state, energy_o and vad_o on the next edge.
